parking_gate_ctrl: RTL and testbench

PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

---
 rtl/parking_pkg.sv | 11 +
 rtl/parking_gate_timer.sv | 32 +++
 rtl/parking_gate_ctrl.sv | 146 ++++++++++++++
 tb/tb_parking_gate_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared sizes and the gate FSM state type for the parking gate controller.
package parking_pkg;
  localparam int unsigned TOTAL_SLOTS_DEF = 15;
  localparam int unsigned COUNT_W         = 4;

  typedef enum logic [1:0] {
    IDLE,
    ENTRY_OPEN,
    EXIT_OPEN
  } gate_state_e;
endpackage

// File: rtl/parking_gate_timer.sv
// Down-counter holding a barrier open: load starts OPEN_CYCLES, done flags the last open cycle.
module parking_gate_timer #(
  parameter int unsigned OPEN_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);
  localparam int unsigned TW = $clog2(OPEN_CYCLES + 1);

  logic [TW-1:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q;
    if (load) begin
      timer_d = TW'(OPEN_CYCLES);
    end else if (timer_q != '0) begin
      timer_d = timer_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign done = (timer_q == TW'(1));
endmodule

// File: rtl/parking_gate_ctrl.sv
// Entry/exit barrier sequencing with admission control against slot occupancy
// plus cars admitted but not yet seen parking (pending).
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int unsigned TOTAL_SLOTS = TOTAL_SLOTS_DEF,
  parameter int unsigned OPEN_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COUNT_W-1:0] count,
  input  logic               entry_req,
  input  logic               exit_req,
  output logic               entry_gate_open,
  output logic               exit_gate_open,
  output logic               full,
  output logic [COUNT_W-1:0] vacancy,
  output logic               denied
);
  localparam logic [COUNT_W:0] SLOTS_EXT = (COUNT_W + 1)'(TOTAL_SLOTS);

  gate_state_e        state_q, state_d;
  logic               entry_gate_q, entry_gate_d;
  logic               exit_gate_q, exit_gate_d;
  logic               denied_q, denied_d;
  logic               full_q, full_d;
  logic [COUNT_W-1:0] vacancy_q, vacancy_d;
  logic [COUNT_W-1:0] pending_q, pending_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               entry_served_q, entry_served_d;
  logic               exit_served_q, exit_served_d;
  logic               deny_sent_q, deny_sent_d;

  logic               load, done, grant;
  logic [COUNT_W:0]   rise, dec, pend_sum, occupied;

  parking_gate_timer #(
    .OPEN_CYCLES(OPEN_CYCLES)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .load(load),
    .done(done)
  );

  always_comb begin
    state_d        = state_q;
    entry_gate_d   = entry_gate_q;
    exit_gate_d    = exit_gate_q;
    denied_d       = 1'b0;
    entry_served_d = entry_served_q;
    exit_served_d  = exit_served_q;
    deny_sent_d    = deny_sent_q;
    count_d        = count;
    load           = 1'b0;
    grant          = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (exit_req && !exit_served_q) begin
          state_d       = EXIT_OPEN;
          exit_gate_d   = 1'b1;
          exit_served_d = 1'b1;
          load          = 1'b1;
        end else if (entry_req && !entry_served_q && !full_q) begin
          state_d        = ENTRY_OPEN;
          entry_gate_d   = 1'b1;
          entry_served_d = 1'b1;
          load           = 1'b1;
          grant          = 1'b1;
        end else if (entry_req && full_q && !deny_sent_q) begin
          denied_d    = 1'b1;
          deny_sent_d = 1'b1;
        end
      end
      ENTRY_OPEN, EXIT_OPEN: begin
        if (done) begin
          state_d      = IDLE;
          entry_gate_d = 1'b0;
          exit_gate_d  = 1'b0;
        end
      end
      default: begin
        state_d      = IDLE;
        entry_gate_d = 1'b0;
        exit_gate_d  = 1'b0;
      end
    endcase

    // A loop must go low before the same car can be served or refused again.
    if (!entry_req) begin
      entry_served_d = 1'b0;
      deny_sent_d    = 1'b0;
    end
    if (!exit_req) begin
      exit_served_d = 1'b0;
    end

    // Only increases in occupancy retire admitted cars; departures are ignored.
    rise     = (count > count_q) ? ({1'b0, count} - {1'b0, count_q}) : '0;
    dec      = (rise < {1'b0, pending_q}) ? rise : {1'b0, pending_q};
    pend_sum = {1'b0, pending_q} + {{COUNT_W{1'b0}}, grant} - dec;
    if (pend_sum > SLOTS_EXT) begin
      pend_sum = SLOTS_EXT;
    end
    pending_d = pend_sum[COUNT_W-1:0];

    occupied  = {1'b0, count} + {1'b0, pending_d};
    full_d    = (occupied >= SLOTS_EXT);
    vacancy_d = full_d ? '0 : COUNT_W'(SLOTS_EXT - occupied);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      entry_gate_q   <= 1'b0;
      exit_gate_q    <= 1'b0;
      denied_q       <= 1'b0;
      full_q         <= 1'b0;
      vacancy_q      <= COUNT_W'(TOTAL_SLOTS);
      pending_q      <= '0;
      count_q        <= '0;
      entry_served_q <= 1'b0;
      exit_served_q  <= 1'b0;
      deny_sent_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      entry_gate_q   <= entry_gate_d;
      exit_gate_q    <= exit_gate_d;
      denied_q       <= denied_d;
      full_q         <= full_d;
      vacancy_q      <= vacancy_d;
      pending_q      <= pending_d;
      count_q        <= count_d;
      entry_served_q <= entry_served_d;
      exit_served_q  <= exit_served_d;
      deny_sent_q    <= deny_sent_d;
    end
  end

  assign entry_gate_open = entry_gate_q;
  assign exit_gate_open  = exit_gate_q;
  assign full            = full_q;
  assign vacancy         = vacancy_q;
  assign denied          = denied_q;
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Scoreboarded bench: stimulus queues the expected output vector and cycle of
// every output change; a negedge monitor pops and compares on each change.
module tb_parking_gate_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] count = 4'd0;
  logic       entry_req = 1'b0;
  logic       exit_req = 1'b0;
  logic       entry_gate_open, exit_gate_open, full, denied;
  logic [3:0] vacancy;

  parking_gate_ctrl #(
    .TOTAL_SLOTS(15),
    .OPEN_CYCLES(16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .count          (count),
    .entry_req      (entry_req),
    .exit_req       (exit_req),
    .entry_gate_open(entry_gate_open),
    .exit_gate_open (exit_gate_open),
    .full           (full),
    .vacancy        (vacancy),
    .denied         (denied)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] vec;   // {entry_gate, exit_gate, full, denied, vacancy[3:0]}
    string      name;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  logic [7:0] cur_vec;
  logic [7:0] prev_vec = 8'h0F;
  exp_t       mon_e;

  assign cur_vec = {entry_gate_open, exit_gate_open, full, denied, vacancy};

  task automatic push_exp(input int off, input logic eg, input logic xg, input logic fl,
                          input logic dn, input logic [3:0] vac, input string name);
    exp_t e;
    int   idx;
    e.cyc  = cyc + off;
    e.vec  = {eg, xg, fl, dn, vac};
    e.name = name;
    idx    = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc > e.cyc) begin
        idx = i;
        break;
      end
    end
    sb.insert(idx, e);
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %b, required %b", name, got, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (cur_vec !== prev_vec) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: cycle %0d got %b, required no change from %b",
                 cyc, cur_vec, prev_vec);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.cyc != cyc || cur_vec !== mon_e.vec) begin
          errors++;
          $display("FAIL %s: got cycle %0d vec %b, required cycle %0d vec %b",
                   mon_e.name, cyc, cur_vec, mon_e.cyc, mon_e.vec);
        end
      end
      prev_vec = cur_vec;
    end
  end

  initial begin
    #12;
    chk("reset_hold", cur_vec, 8'h0F);
    step(2);
    rst = 1'b0;
    step(2);
    chk("after_reset_release", cur_vec, 8'h0F);

    // A: single admission, held loop gives exactly one opening
    count = 4'd3;
    push_exp(1, 0, 0, 0, 0, 4'd12, "A_vac12");
    step(1);
    entry_req = 1'b1;
    push_exp(1,  1, 0, 0, 0, 4'd11, "A_open");
    push_exp(17, 0, 0, 0, 0, 4'd11, "A_close");
    step(5);
    entry_req = 1'b0;
    step(20);
    count = 4'd4;
    step(2);
    count = 4'd0;
    push_exp(1, 0, 0, 0, 0, 4'd15, "A_clear");
    step(2);

    // B: full denial, exit frees a slot, held entry admitted afterwards
    count = 4'd14;
    push_exp(1, 0, 0, 0, 0, 4'd1, "B_vac1");
    step(1);
    entry_req = 1'b1;
    push_exp(1,  1, 0, 1, 0, 4'd0, "B_open");
    push_exp(17, 0, 0, 1, 0, 4'd0, "B_close");
    step(3);
    entry_req = 1'b0;
    step(16);
    entry_req = 1'b1;
    push_exp(1, 0, 0, 1, 1, 4'd0, "B_denied");
    push_exp(2, 0, 0, 1, 0, 4'd0, "B_denied_end");
    step(3);
    exit_req = 1'b1;
    push_exp(1, 0, 1, 1, 0, 4'd0, "B_exit_open");
    step(2);
    exit_req = 1'b0;
    count    = 4'd13;
    push_exp(1,  0, 1, 0, 0, 4'd1, "B_vac_after_leave");
    push_exp(15, 0, 0, 0, 0, 4'd1, "B_exit_close");
    push_exp(16, 1, 0, 1, 0, 4'd0, "B_entry_open");
    push_exp(32, 0, 0, 1, 0, 4'd0, "B_entry_close");
    step(35);
    entry_req = 1'b0;
    count     = 4'd15;
    step(2);
    count = 4'd0;
    push_exp(1, 0, 0, 0, 0, 4'd15, "B_clear");
    step(2);

    // C: simultaneous requests, exit served first
    entry_req = 1'b1;
    exit_req  = 1'b1;
    push_exp(1,  0, 1, 0, 0, 4'd15, "C_exit_first");
    push_exp(17, 0, 0, 0, 0, 4'd15, "C_exit_close");
    push_exp(18, 1, 0, 0, 0, 4'd14, "C_entry_open");
    push_exp(34, 0, 0, 0, 0, 4'd14, "C_entry_close");
    step(3);
    exit_req = 1'b0;
    step(17);
    entry_req = 1'b0;
    step(16);

    // D: grant and park in the same cycle cancel out
    count = 4'd5;
    push_exp(1, 0, 0, 0, 0, 4'd10, "D_park5");
    step(1);
    entry_req = 1'b1;
    push_exp(1,  1, 0, 0, 0, 4'd9, "D_open1");
    push_exp(17, 0, 0, 0, 0, 4'd9, "D_close1");
    step(2);
    entry_req = 1'b0;
    step(16);
    entry_req = 1'b1;
    count     = 4'd6;
    push_exp(1,  1, 0, 0, 0, 4'd8, "D_grant_and_rise");
    push_exp(17, 0, 0, 0, 0, 4'd8, "D_close2");
    step(2);
    entry_req = 1'b0;
    step(18);

    // E: asynchronous reset in the middle of an opening
    count = 4'd0;
    push_exp(1, 0, 0, 0, 0, 4'd14, "E_vac14");
    step(1);
    entry_req = 1'b1;
    push_exp(1, 1, 0, 0, 0, 4'd13, "E_open");
    push_exp(7, 0, 0, 0, 0, 4'd15, "E_reset");
    step(3);
    entry_req = 1'b0;
    step(4);
    #2 rst = 1'b1;
    #1 chk("E_async_reset", cur_vec, 8'h0F);
    step(2);
    rst = 1'b0;
    step(3);
    entry_req = 1'b1;
    push_exp(1,  1, 0, 0, 0, 4'd14, "E_after_reset_open");
    push_exp(17, 0, 0, 0, 0, 4'd14, "E_after_reset_close");
    step(2);
    entry_req = 1'b0;
    step(20);

    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: got no output change, required cycle %0d vec %b",
               mon_e.name, mon_e.cyc, mon_e.vec);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
